// File: rtl/if_fetch_stage_pkg.sv
// Package for the MIPS PPU instruction-fetch stage.
// Holds the shared instruction-set constants used by the fetch stage, its
// interface and the PC/nPC register.
//   INSTR_W  : instruction word width
//   MIPS_NOP : encoding loaded into IF/ID for a bubble
//   PC_STEP  : byte distance between sequential instructions
package if_fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] MIPS_NOP = 32'h0000_0000;
    localparam int PC_STEP = 4;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage : if_fetch_stage_pkg

// File: rtl/if_fetch_stage_if.sv
// Bus interface of the instruction-fetch stage.
// Groups the hazard-unit controls, the branch redirect, the instruction
// memory port and the IF/ID register outputs.
//   master : the fetch stage (drives imem_addr and ifid_*)
//   slave  : the surrounding pipeline / memory (drives controls and imem_rdata)
interface if_fetch_stage_if
    import if_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] imem_addr;
    instr_t            imem_rdata;
    instr_t            ifid_instr;
    logic [ADDR_W-1:0] ifid_pc;
    logic [ADDR_W-1:0] ifid_pc8;
    logic              ifid_valid;

    modport master (
        input  stall, flush, branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_instr, ifid_pc, ifid_pc8, ifid_valid
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_instr, ifid_pc, ifid_pc8, ifid_valid
    );

endinterface : if_fetch_stage_if

// File: rtl/if_fetch_stage_pc_npc_register.sv
// PC/nPC register pair giving one architectural branch delay slot.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   stall          : 1 = hold both PC and nPC (branch_taken ignored)
//   branch_taken   : 1 = nPC takes the aligned branch_target on this edge
//   branch_target  : redirect address, low two bits forced to zero
//   pc, npc        : current fetch address and the one after it
// Sequential increments wrap modulo 2^ADDR_W.
module pc_npc_register
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc
);

    localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] npc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] npc_next_s;

    // Next PC/nPC: PC always follows nPC, so a redirect lands one fetch later.
    always_comb begin
        pc_next_s  = pc_r;
        npc_next_s = npc_r;
        if (stall) begin
            pc_next_s  = pc_r;
            npc_next_s = npc_r;
        end else begin
            pc_next_s = npc_r;
            if (branch_taken) begin
                npc_next_s = branch_target & ALIGN_MASK;
            end else begin
                npc_next_s = npc_r + STEP_C;
            end
        end
    end

    // PC/nPC state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r  <= RESET_PC;
            npc_r <= RESET_PC + STEP_C;
        end else begin
            pc_r  <= pc_next_s;
            npc_r <= npc_next_s;
        end
    end

    assign pc  = pc_r;
    assign npc = npc_r;

endmodule : pc_npc_register

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the MIPS PPU, upstream of decode/control.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : if_fetch_stage_if.master -- stall/flush from the hazard
//                  unit, branch redirect, instruction memory port
//                  (imem_addr = PC, combinational) and the registered
//                  IF/ID outputs ifid_instr/ifid_pc/ifid_pc8/ifid_valid
//   perf_fetch_cnt, perf_stall_cnt : only when IF_PERF_COUNT_EN is defined;
//                  count real fetches (stall=0, flush=0) and stalled edges
// Optional feature macro: IF_PERF_COUNT_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    if_fetch_stage_if.master  bus
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LINK_OFS = ADDR_W'(2 * PC_STEP);

    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] npc_s;

    instr_t            ifid_instr_r;
    logic [ADDR_W-1:0] ifid_pc_r;
    logic [ADDR_W-1:0] ifid_pc8_r;
    logic              ifid_valid_r;

    instr_t            instr_next_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc8_next_s;
    logic              valid_next_s;

    pc_npc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_npc (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .pc            (pc_s),
        .npc           (npc_s)
    );

    assign bus.imem_addr = pc_s;

    // IF/ID next state: flush forces a bubble even while stalled; the PC
    // fields follow the fetch and therefore freeze whenever PC freezes.
    always_comb begin
        instr_next_s = ifid_instr_r;
        valid_next_s = ifid_valid_r;
        pc_next_s    = ifid_pc_r;
        pc8_next_s   = ifid_pc8_r;
        if (bus.flush) begin
            instr_next_s = MIPS_NOP;
            valid_next_s = 1'b0;
        end else if (!bus.stall) begin
            instr_next_s = bus.imem_rdata;
            valid_next_s = 1'b1;
        end else begin
            instr_next_s = ifid_instr_r;
            valid_next_s = ifid_valid_r;
        end
        if (!bus.stall) begin
            pc_next_s  = pc_s;
            pc8_next_s = pc_s + LINK_OFS;
        end else begin
            pc_next_s  = ifid_pc_r;
            pc8_next_s = ifid_pc8_r;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifid_instr_r <= MIPS_NOP;
            ifid_pc_r    <= {ADDR_W{1'b0}};
            ifid_pc8_r   <= {ADDR_W{1'b0}};
            ifid_valid_r <= 1'b0;
        end else begin
            ifid_instr_r <= instr_next_s;
            ifid_pc_r    <= pc_next_s;
            ifid_pc8_r   <= pc8_next_s;
            ifid_valid_r <= valid_next_s;
        end
    end

    assign bus.ifid_instr = ifid_instr_r;
    assign bus.ifid_pc    = ifid_pc_r;
    assign bus.ifid_pc8   = ifid_pc8_r;
    assign bus.ifid_valid = ifid_valid_r;

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;

    // Performance counters; both wrap silently at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (!bus.stall && !bus.flush) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end else begin
                fetch_cnt_r <= fetch_cnt_r;
            end
            if (bus.stall) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_r;
    assign perf_stall_cnt = stall_cnt_r;
`endif

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized stall/flush/branch traffic, checked against a queue-based
// model of the fetch address stream.
module tb_if_fetch_stage;

    logic clk;
    logic reset_n;

    if_fetch_stage_if #(.ADDR_W(32)) bus_a ();
    if_fetch_stage_if #(.ADDR_W(32)) bus_b ();

`ifdef IF_PERF_COUNT_EN
    logic [31:0] perf_fetch_a, perf_stall_a, perf_fetch_b, perf_stall_b;
`endif

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
`ifdef IF_PERF_COUNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_a),
        .perf_stall_cnt (perf_stall_a)
`endif
    );

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
`ifdef IF_PERF_COUNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_b),
        .perf_stall_cnt (perf_stall_b)
`endif
    );

    // Instruction memory: each word is a distinct function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign bus_a.imem_rdata = mem_word(bus_a.imem_addr);
    assign bus_b.imem_rdata = mem_word(bus_b.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the upcoming fetch addresses in order, plus IF/ID.
    logic [31:0] fq[$];
    logic [31:0] m_instr, m_pc, m_pc8;
    logic        m_valid;
    bit          m_pc_known;
    logic [31:0] m_fetch_cnt, m_stall_cnt;

    task automatic model_reset();
        fq.delete();
        fq.push_back(32'h0000_0000);
        fq.push_back(32'h0000_0004);
        m_instr = 32'h0; m_pc = 32'h0; m_pc8 = 32'h0; m_valid = 1'b0;
        m_pc_known = 1'b1;
        m_fetch_cnt = 32'd0; m_stall_cnt = 32'd0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic b, input logic [31:0] t);
        logic [31:0] cur;
        cur = fq[0];
        if (!s) begin
            m_pc = cur;
            m_pc8 = cur + 32'd8;
            m_pc_known = 1'b1;
            m_instr = f ? 32'h0 : mem_word(cur);
            m_valid = !f;
            void'(fq.pop_front());
            fq.push_back(b ? {t[31:2], 2'b00} : fq[0] + 32'd4);
        end else if (f) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_pc_known = 1'b0;
        end
        if (!s && !f) m_fetch_cnt = m_fetch_cnt + 32'd1;
        if (s) m_stall_cnt = m_stall_cnt + 32'd1;
    endtask

    task automatic compare_all();
        check_eq("imem_addr", bus_a.imem_addr, fq[0]);
        check_eq("ifid_instr", bus_a.ifid_instr, m_instr);
        check_eq("ifid_valid", {31'b0, bus_a.ifid_valid}, {31'b0, m_valid});
        if (m_pc_known) begin
            check_eq("ifid_pc", bus_a.ifid_pc, m_pc);
            check_eq("ifid_pc8", bus_a.ifid_pc8, m_pc8);
        end
`ifdef IF_PERF_COUNT_EN
        check_eq("perf_fetch", perf_fetch_a, m_fetch_cnt);
        check_eq("perf_stall", perf_stall_a, m_stall_cnt);
`endif
    endtask

    // One clock: apply inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
        bus_a.stall = s;
        bus_a.flush = f;
        bus_a.branch_taken = b;
        bus_a.branch_target = t;
        model_edge(s, f, b, t);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_imem_addr"}, bus_a.imem_addr, 32'h0);
        check_eq({tag, "_instr"}, bus_a.ifid_instr, 32'h0);
        check_eq({tag, "_pc"}, bus_a.ifid_pc, 32'h0);
        check_eq({tag, "_pc8"}, bus_a.ifid_pc8, 32'h0);
        check_eq({tag, "_valid"}, {31'b0, bus_a.ifid_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        logic        s, f, b;
        reset_n = 1'b0;
        bus_a.stall = 1'b0; bus_a.flush = 1'b0;
        bus_a.branch_taken = 1'b0; bus_a.branch_target = 32'h0;
        bus_b.stall = 1'b0; bus_b.flush = 1'b0;
        bus_b.branch_taken = 1'b0; bus_b.branch_target = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        check_eq("b_rst_addr", bus_b.imem_addr, 32'hFFFF_FFF8);
        reset_n = 1'b1;

        // Sequential fetch from reset; second instance walks across the wrap.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("seq_addr1", bus_a.imem_addr, 32'h4);
        check_eq("seq_pc0", bus_a.ifid_pc, 32'h0);
        check_eq("seq_valid0", {31'b0, bus_a.ifid_valid}, 32'h1);
        check_eq("b_addr1", bus_b.imem_addr, 32'hFFFF_FFFC);
        check_eq("b_pc8_1", bus_b.ifid_pc8, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("seq_addr2", bus_a.imem_addr, 32'h8);
        check_eq("b_addr2", bus_b.imem_addr, 32'h0000_0000);
        check_eq("b_pc2", bus_b.ifid_pc, 32'hFFFF_FFFC);
        check_eq("b_pc8_2", bus_b.ifid_pc8, 32'h0000_0004);

        // Branch at PC=8: delay slot 12 then target 0x40 (low bits ignored).
        step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
        check_eq("br_slot", bus_a.imem_addr, 32'hC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("br_tgt", bus_a.imem_addr, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("br_tgt4", bus_a.imem_addr, 32'h44);

        // Stall three cycles with a held branch request, then flush under stall.
        repeat (3) step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        check_eq("stall_addr", bus_a.imem_addr, 32'h44);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("fl_st_instr", bus_a.ifid_instr, 32'h0);
        check_eq("fl_st_valid", {31'b0, bus_a.ifid_valid}, 32'h0);
        check_eq("fl_st_addr", bus_a.imem_addr, 32'h44);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 15);
            b = ($urandom_range(0, 99) < 20);
            tgt = $urandom();
            step(s, f, b, tgt);
        end

        // Asynchronous reset mid-cycle while a branch is requested.
        bus_a.branch_taken = 1'b1;
        bus_a.branch_target = 32'h0000_0200;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        bus_a.branch_taken = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("held");
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 99) < 20);
            f = ($urandom_range(0, 99) < 10);
            b = ($urandom_range(0, 99) < 20);
            tgt = $urandom();
            step(s, f, b, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_if_fetch_stage
